// File: rtl/chess_move_entry_if.sv
// Button/display bundle for the chess move-entry front end.
// Ports (signals):
//   key_file_n, key_rank_n, key_submit_n : raw active-low buttons (master -> slave)
//   user_digit1, user_digit2             : selected file/rank codes (slave -> master)
//   verify                               : idle-high submit line (slave -> master)
//   preview_digit0, preview_digit1       : 5-bit display glyphs (slave -> master)
//   busy                                 : submit FSM not idle (slave -> master)
interface chess_move_entry_if;
  logic       key_file_n;
  logic       key_rank_n;
  logic       key_submit_n;
  logic [3:0] user_digit1;
  logic [3:0] user_digit2;
  logic       verify;
  logic [4:0] preview_digit0;
  logic [4:0] preview_digit1;
  logic       busy;

  modport master (
    output key_file_n, key_rank_n, key_submit_n,
    input  user_digit1, user_digit2, verify, preview_digit0, preview_digit1, busy
  );

  modport slave (
    input  key_file_n, key_rank_n, key_submit_n,
    output user_digit1, user_digit2, verify, preview_digit0, preview_digit1, busy
  );
endinterface

// File: rtl/chess_move_entry.sv
// Chess move entry: debounces three pushbuttons, lets the player select a square
// (file a-h coded 8..15, rank 1-8 coded 0..7) and emits one verify low pulse per
// physical submit press.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : chess_move_entry_if.slave (buttons in; digits, verify, preview, busy out)
module chess_move_entry #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned VERIFY_LOW_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  chess_move_entry_if.slave bus
);

  localparam int unsigned N_KEYS     = 3;
  localparam int unsigned KEY_FILE   = 0;
  localparam int unsigned KEY_RANK   = 1;
  localparam int unsigned KEY_SUBMIT = 2;

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW   = (VERIFY_LOW_CYCLES > 1) ? $clog2(VERIFY_LOW_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]   PULSE_LAST = PW'(VERIFY_LOW_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [N_KEYS-1:0] raw;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] stable_q;
  logic [N_KEYS-1:0] press_q;
  logic [DB_W-1:0]   db_cnt_q [N_KEYS];

  logic [3:0]    digit1_q;
  logic [3:0]    digit2_q;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic          verify_q;
  logic          verify_d;
  logic          busy_q;
  logic          busy_d;
  logic          sel_en;

  assign raw = {bus.key_submit_n, bus.key_rank_n, bus.key_file_n};

  // Synchronize and debounce; press_q strobes for one cycle when a stable level falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            stable_q[i] <= sync2_q[i];
            db_cnt_q[i] <= '0;
            // Old stable level 1 means this toggle is a press, not a release.
            press_q[i]  <= stable_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Selection is frozen while a submit is in flight or being accepted this cycle.
  assign sel_en = (state_q == ST_IDLE) && !press_q[KEY_SUBMIT];

  // File/rank selection with wrap-around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit1_q <= 4'd8;
      digit2_q <= 4'd0;
    end else if (sel_en) begin
      if (press_q[KEY_FILE]) begin
        digit1_q <= (digit1_q == 4'd15) ? 4'd8 : digit1_q + 4'd1;
      end
      if (press_q[KEY_RANK]) begin
        digit2_q <= (digit2_q == 4'd7) ? 4'd0 : digit2_q + 4'd1;
      end
    end
  end

  // Submit FSM: state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pcnt_q   <= '0;
      verify_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      verify_q <= verify_d;
      busy_q   <= busy_d;
    end
  end

  // Submit FSM: next state and next outputs.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    verify_d = verify_q;
    busy_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        verify_d = 1'b1;
        if (press_q[KEY_SUBMIT]) begin
          state_d  = ST_PULSE;
          verify_d = 1'b0;
          pcnt_d   = PULSE_LAST;
        end
      end
      ST_PULSE: begin
        verify_d = 1'b0;
        if (pcnt_q == '0) begin
          verify_d = 1'b1;
          state_d  = ST_RELEASE;
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      ST_RELEASE: begin
        verify_d = 1'b1;
        // Wait for the debounced release so a held button yields one pulse.
        if (stable_q[KEY_SUBMIT]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        verify_d = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.user_digit1    = digit1_q;
  assign bus.user_digit2    = digit2_q;
  assign bus.verify         = verify_q;
  assign bus.busy           = busy_q;
  assign bus.preview_digit0 = {1'b0, digit2_q};
  assign bus.preview_digit1 = {1'b0, digit1_q};

endmodule

// File: tb/tb_chess_move_entry.sv
// Directed bench for chess_move_entry with DEBOUNCE_CYCLES=4, VERIFY_LOW_CYCLES=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_chess_move_entry;

  localparam int unsigned K_FILE   = 0;
  localparam int unsigned K_RANK   = 1;
  localparam int unsigned K_SUBMIT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  chess_move_entry_if bus ();

  chess_move_entry #(
    .DEBOUNCE_CYCLES  (4),
    .VERIFY_LOW_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Verify-line monitor: counts falling edges and low cycles.
  int unsigned fall_cnt = 0;
  int unsigned low_cnt = 0;
  logic verify_prev = 1'b1;

  always @(negedge clk) begin
    if (bus.verify === 1'b0) low_cnt++;
    if (verify_prev === 1'b1 && bus.verify === 1'b0) fall_cnt++;
    verify_prev = bus.verify;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_key(input int unsigned key, input logic val);
    case (key)
      K_FILE:  bus.key_file_n = val;
      K_RANK:  bus.key_rank_n = val;
      default: bus.key_submit_n = val;
    endcase
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a key low for 'low' cycles, then release and let the release settle.
  task automatic tap(input int unsigned key, input int low);
    @(negedge clk);
    set_key(key, 1'b0);
    wait_cyc(low);
    set_key(key, 1'b1);
    wait_cyc(12);
  endtask

  task automatic tap_both(input int low);
    @(negedge clk);
    bus.key_file_n = 1'b0;
    bus.key_rank_n = 1'b0;
    wait_cyc(low);
    bus.key_file_n = 1'b1;
    bus.key_rank_n = 1'b1;
    wait_cyc(12);
  endtask

  initial begin
    int unsigned fc0;
    int unsigned lc0;
    int k;

    bus.key_file_n   = 1'b1;
    bus.key_rank_n   = 1'b1;
    bus.key_submit_n = 1'b1;

    // 1. Reset values.
    wait_cyc(3);
    check("rst_digit1", 32'(bus.user_digit1), 8);
    check("rst_digit2", 32'(bus.user_digit2), 0);
    check("rst_verify", 32'(bus.verify), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_prev0", 32'(bus.preview_digit0), 0);
    check("rst_prev1", 32'(bus.preview_digit1), 8);
    rst_n = 1'b1;
    wait_cyc(3);

    // 2. File and rank stepping with wrap.
    for (int i = 0; i < 8; i++) begin
      tap(K_FILE, 8);
      check($sformatf("file_step%0d", i), 32'(bus.user_digit1), (i == 7) ? 8 : 9 + i);
    end
    for (int i = 0; i < 8; i++) begin
      tap(K_RANK, 8);
      check($sformatf("rank_step%0d", i), 32'(bus.user_digit2), (i == 7) ? 0 : 1 + i);
    end

    // 3. Short glitch ignored, long enough press accepted once.
    tap(K_FILE, 3);
    check("glitch_3", 32'(bus.user_digit1), 8);
    tap(K_FILE, 6);
    check("press_6", 32'(bus.user_digit1), 9);
    check("press_6_prev1", 32'(bus.preview_digit1), 9);

    // 4. Held submit: one pulse, fixed latency, busy until release.
    #1;
    fc0 = fall_cnt;
    lc0 = low_cnt;
    @(negedge clk);
    bus.key_submit_n = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (bus.verify === 1'b0) break;
    end
    check("submit_latency", 32'(k), 7);
    check("busy_in_pulse", 32'(bus.busy), 1);
    wait_cyc(100 - k);
    check("busy_held", 32'(bus.busy), 1);
    #1;
    check("held_falls", fall_cnt - fc0, 1);
    check("held_low_cycles", low_cnt - lc0, 4);
    @(negedge clk);
    bus.key_submit_n = 1'b1;
    wait_cyc(6);
    check("busy_rel6", 32'(bus.busy), 1);
    wait_cyc(1);
    check("busy_rel7", 32'(bus.busy), 0);
    check("verify_idle", 32'(bus.verify), 1);
    wait_cyc(10);

    // 5. Move to e4 with simultaneous file+rank presses, then submit with
    //    a file press in the same cycle and a rank press during the pulse.
    for (int i = 0; i < 3; i++) tap_both(8);
    check("e4_digit1", 32'(bus.user_digit1), 12);
    check("e4_digit2", 32'(bus.user_digit2), 3);
    #1;
    fc0 = fall_cnt;
    lc0 = low_cnt;
    @(negedge clk);
    bus.key_file_n   = 1'b0;
    bus.key_submit_n = 1'b0;
    wait_cyc(2);
    bus.key_rank_n = 1'b0;
    wait_cyc(30);
    check("e4_busy_held", 32'(bus.busy), 1);
    bus.key_file_n   = 1'b1;
    bus.key_rank_n   = 1'b1;
    bus.key_submit_n = 1'b1;
    wait_cyc(20);
    check("e4_after_digit1", 32'(bus.user_digit1), 12);
    check("e4_after_digit2", 32'(bus.user_digit2), 3);
    check("e4_prev0", 32'(bus.preview_digit0), 3);
    check("e4_busy_done", 32'(bus.busy), 0);
    #1;
    check("e4_falls", fall_cnt - fc0, 1);
    check("e4_low_cycles", low_cnt - lc0, 4);

    // 6. Reset during the second pulse cycle.
    @(negedge clk);
    bus.key_submit_n = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (bus.verify === 1'b0) break;
    end
    check("rstmid_latency", 32'(k), 7);
    @(negedge clk);
    check("rstmid_low_before", 32'(bus.verify), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_verify", 32'(bus.verify), 1);
    check("rstmid_busy", 32'(bus.busy), 0);
    check("rstmid_digit1", 32'(bus.user_digit1), 8);
    check("rstmid_digit2", 32'(bus.user_digit2), 0);
    bus.key_submit_n = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    #1;
    fc0 = fall_cnt;
    wait_cyc(40);
    #1;
    check("rstmid_no_second", fall_cnt - fc0, 0);
    check("rstmid_verify_end", 32'(bus.verify), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
